inst_prefetch_queue: RTL and testbench

//  Instruction prefetch stage between the core's fetch port and instruction memory.

---
 rtl/inst_prefetch_queue_pkg.sv | 22 ++
 rtl/pfq_fifo.sv | 68 ++++++
 rtl/inst_prefetch_queue.sv | 135 +++++++++++++
 tb/tb_inst_prefetch_queue.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_prefetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch queue.
// Holds FSM encodings, the queue entry layout and an alignment helper.
package inst_prefetch_queue_pkg;

  localparam logic RST_ENABLE = 1'b0;

  localparam logic [1:0] PFQ_IDLE = 2'd0;
  localparam logic [1:0] PFQ_REQ  = 2'd1;
  localparam logic [1:0] PFQ_DROP = 2'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } pfq_entry_t;

  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pfq_fifo.sv
// Synchronous FIFO of {pc,inst} entries with a registered head.
// The head register is loaded one cycle after the entry is pushed.
module pfq_fifo
  import inst_prefetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  pfq_entry_t    push_data,
  input  logic          pop,
  input  logic          clear,
  output logic [AW:0]   count,
  output logic          head_valid,
  output pfq_entry_t    head
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  pfq_entry_t    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_nxt;
  logic [AW:0]   remain;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL) || do_pop);
  assign remain  = count - (AW+1)'(do_pop);
  assign rd_nxt  = rd_ptr + AW'(do_pop);

  // Storage array, written at the tail.
  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, occupancy and the registered head entry.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
      head       <= '0;
    end else if (clear) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr + AW'(do_push);
      rd_ptr     <= rd_nxt;
      count      <= remain + (AW+1)'(do_push);
      head_valid <= (remain != '0) || do_push;
      if (remain != '0) begin
        head <= mem[rd_nxt];
      end else if (do_push) begin
        head <= push_data;
      end
    end
  end

endmodule

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch: sequential fetch FSM over a req/ack memory port.
// Fetched {pc,inst} pairs are buffered in pfq_fifo; redirect flushes all.
module inst_prefetch_queue
  import inst_prefetch_queue_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  input  logic        inst_ready_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [1:0]    state;
  logic [1:0]    state_n;
  logic [31:0]   fetch_pc;
  logic [31:0]   pc_n;
  logic [31:0]   pc_inc;
  logic [31:0]   flush_pc;
  logic          req_n;
  logic [31:0]   addr_n;
  logic          ack;
  logic          push;
  logic          pop;
  logic          room_idle;
  logic          room_ack;
  logic [AW:0]   count;
  logic [AW+1:0] count_inc;
  pfq_entry_t    push_data;
  pfq_entry_t    head;

  assign ack       = mem_ack_i && mem_req_o;
  assign pop       = inst_valid_o && inst_ready_i && !flush_i;
  assign push      = ack && (state == PFQ_REQ) && !flush_i;
  assign pc_inc    = fetch_pc + 32'd4;
  assign flush_pc  = word_align(flush_pc_i);
  assign count_inc = {1'b0, count} + (AW+2)'(1);
  assign room_idle = count < FULL;
  assign room_ack  = (count_inc < {1'b0, FULL}) || pop;

  assign push_data.pc   = fetch_pc;
  assign push_data.inst = mem_data_i;

  assign inst_o    = head.inst;
  assign inst_pc_o = head.pc;

  pfq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_data  (push_data),
    .pop        (pop),
    .clear      (flush_i),
    .count      (count),
    .head_valid (inst_valid_o),
    .head       (head)
  );

  // Fetch FSM: issue, hold until ack, chain or drop on redirect.
  always_comb begin
    state_n = state;
    req_n   = mem_req_o;
    addr_n  = mem_addr_o;
    pc_n    = fetch_pc;
    case (state)
      PFQ_IDLE: begin
        if (flush_i) begin
          pc_n = flush_pc;
        end else if (room_idle) begin
          state_n = PFQ_REQ;
          req_n   = 1'b1;
          addr_n  = fetch_pc;
        end
      end
      PFQ_REQ, PFQ_DROP: begin
        if (flush_i) begin
          pc_n = flush_pc;
          if (ack) begin
            state_n = PFQ_REQ;
            req_n   = 1'b1;
            addr_n  = flush_pc;
          end else begin
            state_n = PFQ_DROP;
          end
        end else if (ack && state == PFQ_DROP) begin
          state_n = PFQ_REQ;
          req_n   = 1'b1;
          addr_n  = fetch_pc;
        end else if (ack) begin
          pc_n = pc_inc;
          if (room_ack) begin
            addr_n = pc_inc;
          end else begin
            state_n = PFQ_IDLE;
            req_n   = 1'b0;
          end
        end
      end
      default: begin
        state_n = PFQ_IDLE;
        req_n   = 1'b0;
      end
    endcase
  end

  // FSM state, fetch pointer and registered memory request.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      state      <= PFQ_IDLE;
      fetch_pc   <= word_align(RESET_PC);
      mem_req_o  <= 1'b0;
      mem_addr_o <= '0;
    end else begin
      state      <= state_n;
      fetch_pc   <= pc_n;
      mem_req_o  <= req_n;
      mem_addr_o <= addr_n;
    end
  end

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Bench for inst_prefetch_queue: memory model with wait states,
// scoreboard of expected {pc,inst}, redirects and reset checks.
module tb_inst_prefetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] flush_pc_i = '0;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_ready_i = 1'b0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_data_i = '0;

  logic        hi_valid;
  logic [31:0] hi_inst;
  logic [31:0] hi_pc;
  logic        hi_req;
  logic [31:0] hi_addr;
  logic        hi_ack;
  logic [31:0] hi_data;
  logic        hi_ready = 1'b1;
  logic        hi_flush = 1'b0;
  logic [31:0] hi_flush_pc = '0;

  always #5 clk = ~clk;

  inst_prefetch_queue #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush_i),
    .flush_pc_i   (flush_pc_i),
    .inst_valid_o (inst_valid_o),
    .inst_o       (inst_o),
    .inst_pc_o    (inst_pc_o),
    .inst_ready_i (inst_ready_i),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_ack_i    (mem_ack_i),
    .mem_data_i   (mem_data_i)
  );

  inst_prefetch_queue #(
    .RESET_PC (32'hFFFF_FFF8),
    .DEPTH    (4)
  ) u_hi (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (hi_flush),
    .flush_pc_i   (hi_flush_pc),
    .inst_valid_o (hi_valid),
    .inst_o       (hi_inst),
    .inst_pc_o    (hi_pc),
    .inst_ready_i (hi_ready),
    .mem_req_o    (hi_req),
    .mem_addr_o   (hi_addr),
    .mem_ack_i    (hi_ack),
    .mem_data_i   (hi_data)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'hA5A5_0F0F;
  endfunction

  assign hi_ack  = hi_req;
  assign hi_data = memf(hi_addr);

  int          n_chk = 0;
  int          n_err = 0;
  logic [63:0] sb [$];
  logic [31:0] exp_fetch = '0;
  logic [31:0] last_addr = '0;
  logic [31:0] drop_addr = '0;
  logic [31:0] hold_pc = '0;
  logic [31:0] flush_pc = '0;
  logic [31:0] hi_exp [3];
  bit          drop = 1'b0;
  bit          chk_flush = 1'b0;
  bit          ready = 1'b0;
  bit          flush_req = 1'b0;
  int          cyc = 0;
  int          wait_st = 0;
  int          pops = 0;
  int          hi_n = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    exp_fetch = 32'h0;
    drop      = 1'b0;
    chk_flush = 1'b0;
    cyc       = 0;
  endtask

  task automatic step();
    logic        ack;
    logic [31:0] a;
    logic [63:0] e;
    @(negedge clk);
    if (chk_flush) begin
      check("flush_empty", 32'(inst_valid_o), 32'd0);
      check("hold_pc", inst_pc_o, hold_pc);
      chk_flush = 1'b0;
    end
    ack = 1'b0;
    a   = mem_addr_o;
    if (rst && mem_req_o) begin
      cyc++;
      if (cyc > 1) check("addr_hold", a, last_addr);
      last_addr = a;
      if (cyc >= wait_st + 1) ack = 1'b1;
    end
    if (rst && !flush_req && inst_valid_o && ready) begin
      if (sb.size() == 0) begin
        check("sb_nonempty", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check("pop_pc", inst_pc_o, e[63:32]);
        check("pop_inst", inst_o, e[31:0]);
      end
      pops++;
    end
    if (ack) begin
      if (drop) begin
        check("drop_addr", a, drop_addr);
        drop = 1'b0;
      end else if (!flush_req) begin
        check("fetch_addr", a, exp_fetch);
        sb.push_back({a, memf(a)});
        exp_fetch += 32'd4;
      end
      cyc = 0;
    end
    if (flush_req) begin
      sb.delete();
      exp_fetch = flush_pc & ~32'h3;
      if (mem_req_o && !ack) begin
        if (!drop) drop_addr = a;
        drop = 1'b1;
      end
      chk_flush = 1'b1;
      hold_pc   = inst_pc_o;
    end
    if (rst && hi_valid && hi_n < 3) begin
      check("hi_pc", hi_pc, hi_exp[hi_n]);
      check("hi_inst", hi_inst, memf(hi_exp[hi_n]));
      hi_n++;
    end
    mem_ack_i    = ack;
    mem_data_i   = ack ? memf(a) : 32'h0BAD_0BAD;
    inst_ready_i = ready;
    flush_i      = flush_req;
    flush_pc_i   = flush_pc;
    flush_req    = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    steps(2);
    rst = 1'b1;
  endtask

  task automatic wait_valid(input int max);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (inst_valid_o) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    if (!seen) check("valid_timeout", 32'(inst_valid_o), 32'd1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_req"}, 32'(mem_req_o), 32'd0);
    check({tag, "_addr"}, mem_addr_o, 32'd0);
    check({tag, "_valid"}, 32'(inst_valid_o), 32'd0);
    check({tag, "_inst"}, inst_o, 32'd0);
    check({tag, "_pc"}, inst_pc_o, 32'd0);
  endtask

  initial begin
    bit found;
    hi_exp[0] = 32'hFFFF_FFF8;
    hi_exp[1] = 32'hFFFF_FFFC;
    hi_exp[2] = 32'h0000_0000;
    #1;
    check_zero("rst");

    // Zero-wait memory, core always ready: one instruction per cycle.
    ready = 1'b1;
    wait_st = 0;
    apply_reset();
    steps(5);
    pops = 0;
    steps(20);
    check("throughput", 32'(pops), 32'd20);
    check("hi_seen", 32'(hi_n), 32'd3);

    // Core stalled: queue fills to DEPTH, requests stop.
    ready = 1'b0;
    apply_reset();
    steps(10);
    check("full_req", 32'(mem_req_o), 32'd0);
    check("full_cnt", 32'(sb.size()), 32'd4);
    check("full_valid", 32'(inst_valid_o), 32'd1);
    check("full_head", inst_pc_o, 32'd0);
    ready = 1'b1;
    steps(20);

    // Three wait states per fetch.
    wait_st = 3;
    apply_reset();
    steps(40);

    // Redirect while the fetch of 0x8 is waiting for ack.
    apply_reset();
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (mem_req_o && mem_addr_o == 32'h8) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) check("req8_timeout", mem_addr_o, 32'h8);
    flush_pc  = 32'h100;
    flush_req = 1'b1;
    step();
    wait_valid(50);
    check("redirect_pc", inst_pc_o, 32'h100);
    steps(10);

    // Address wrap through a redirect near the top.
    wait_st   = 0;
    flush_pc  = 32'hFFFF_FFF9;
    flush_req = 1'b1;
    step();
    wait_valid(20);
    check("wrap_pc", inst_pc_o, 32'hFFFF_FFF8);
    steps(10);

    // Random ready, wait states and redirects.
    for (int i = 0; i < 200; i++) begin
      ready   = 1'($urandom_range(0, 1));
      wait_st = $urandom_range(0, 2);
      if ($urandom_range(0, 15) == 0) begin
        flush_pc  = $urandom;
        flush_req = 1'b1;
      end
      step();
    end
    ready   = 1'b1;
    wait_st = 0;
    steps(20);

    // Asynchronous reset in the middle of a request.
    wait_st = 3;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (mem_req_o) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) check("req_timeout", 32'(mem_req_o), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_zero("async");
    model_reset();
    steps(2);
    rst = 1'b1;
    wait_valid(50);
    check("restart_pc", inst_pc_o, 32'h0);
    steps(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
